// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register that feeds the ALU directly. It picks the ALU
// operands (rs1 data or PC, rs2 data or immediate) and resolves
// read-after-write hazards against the instructions in EX and MEM. When a
// hazard cannot be resolved it inserts a bubble. It also handles a
// downstream stall and a branch flush.
//
// Build option:
//   ID_EX_FORWARD_EN  defined   : operands are forwarded from EX (ALU result)
//                                 and from MEM (write-back value). Only a
//                                 load-use hazard inserts a bubble.
//                     undefined : no forwarding muxes. Any used source that
//                                 matches a pending EX or MEM destination
//                                 stalls until both stages are clear.
//
// Ports:
//   CLK, rst          clock; synchronous active-high reset
//   stall             downstream stall, holds all registered state
//   flush             squash the instruction being captured
//   in_*              decoded instruction from ID
//   ex_fwd_data       ALU result of the instruction currently held here
//   mem_fwd_*         MEM-stage destination and write-back value
//   hazard_stall      combinational; upstream holds PC and IF/ID
//   ex_*              registered ALU-side outputs
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned REG_IDX_W = 5
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [2:0]           in_alu_op,
    input  logic [REG_IDX_W-1:0] in_rs1_idx,
    input  logic [REG_IDX_W-1:0] in_rs2_idx,
    input  logic [REG_IDX_W-1:0] in_rd_idx,
    input  logic [WORD_SIZE-1:0] in_rs1_data,
    input  logic [WORD_SIZE-1:0] in_rs2_data,
    input  logic [WORD_SIZE-1:0] in_imm,
    input  logic [WORD_SIZE-1:0] in_pc,
    input  logic                 in_src1_sel,
    input  logic                 in_src2_sel,
    input  logic                 in_reg_write,
    input  logic                 in_is_load,
    input  logic [WORD_SIZE-1:0] ex_fwd_data,
    input  logic                 mem_fwd_valid,
    input  logic [REG_IDX_W-1:0] mem_fwd_rd,
    input  logic [WORD_SIZE-1:0] mem_fwd_data,
    output logic                 hazard_stall,
    output logic                 ex_valid,
    output logic [2:0]           ex_alu_op,
    output logic [WORD_SIZE-1:0] ex_r1,
    output logic [WORD_SIZE-1:0] ex_r2,
    output logic [REG_IDX_W-1:0] ex_rd_idx,
    output logic                 ex_reg_write,
    output logic                 ex_is_load
);

    // A source is "used" only when it reads a register other than x0.
    logic rs1_used, rs2_used;
    logic ex_wr;
    logic ex_match1, ex_match2;
    logic mem_match1, mem_match2;
    logic load_use;
    logic dep_hazard;
    logic hazard_raw;
    logic [WORD_SIZE-1:0] src1, src2;
    logic [WORD_SIZE-1:0] op1, op2;

    assign rs1_used   = ~in_src1_sel & (in_rs1_idx != '0);
    assign rs2_used   = ~in_src2_sel & (in_rs2_idx != '0);
    assign ex_wr      = ex_valid & ex_reg_write;
    assign ex_match1  = (ex_rd_idx == in_rs1_idx);
    assign ex_match2  = (ex_rd_idx == in_rs2_idx);
    assign mem_match1 = mem_fwd_valid & (mem_fwd_rd == in_rs1_idx);
    assign mem_match2 = mem_fwd_valid & (mem_fwd_rd == in_rs2_idx);

    // A load result is not available until MEM, so its consumer must wait a cycle.
    assign load_use = in_valid & ex_valid & ex_is_load & (ex_rd_idx != '0) &
                      ((rs1_used & ex_match1) | (rs2_used & ex_match2));

`ifdef ID_EX_FORWARD_EN
    logic ex_hit1, ex_hit2;

    assign ex_hit1 = rs1_used & ex_wr & ~ex_is_load & ex_match1;
    assign ex_hit2 = rs2_used & ex_wr & ~ex_is_load & ex_match2;

    // EX is younger than MEM, so it wins when both stages hit.
    always_comb begin
        src1 = in_rs1_data;
        src2 = in_rs2_data;
        if (ex_hit1)
            src1 = ex_fwd_data;
        else if (rs1_used & mem_match1)
            src1 = mem_fwd_data;
        if (ex_hit2)
            src2 = ex_fwd_data;
        else if (rs2_used & mem_match2)
            src2 = mem_fwd_data;
    end

    assign dep_hazard = 1'b0;
`else
    logic unused_fwd;

    assign unused_fwd = ^{ex_fwd_data, mem_fwd_data};

    assign src1 = in_rs1_data;
    assign src2 = in_rs2_data;

    // Without forwarding, wait until no older in-flight instruction writes a used source.
    assign dep_hazard = in_valid &
                        ((rs1_used & ((ex_wr & ex_match1) | mem_match1)) |
                         (rs2_used & ((ex_wr & ex_match2) | mem_match2)));
`endif

    // x0 always reads as zero, whatever the register file returns.
    always_comb begin
        op1 = '0;
        op2 = '0;
        if (in_src1_sel)
            op1 = in_pc;
        else if (in_rs1_idx != '0)
            op1 = src1;
        if (in_src2_sel)
            op2 = in_imm;
        else if (in_rs2_idx != '0)
            op2 = src2;
    end

    assign hazard_raw   = load_use | dep_hazard;
    assign hazard_stall = hazard_raw & ~rst & ~flush;

    always_ff @(posedge CLK) begin
        if (rst || flush || (!stall && (hazard_raw || !in_valid))) begin
            ex_valid     <= 1'b0;
            ex_alu_op    <= '0;
            ex_r1        <= '0;
            ex_r2        <= '0;
            ex_rd_idx    <= '0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
        end else if (!stall) begin
            ex_valid     <= 1'b1;
            ex_alu_op    <= in_alu_op;
            ex_r1        <= op1;
            ex_r2        <= op2;
            ex_rd_idx    <= in_rd_idx;
            ex_reg_write <= in_reg_write;
            ex_is_load   <= in_is_load;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

    logic        CLK = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [2:0]  in_alu_op;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic        in_src1_sel, in_src2_sel, in_reg_write, in_is_load;
    logic [31:0] ex_fwd_data;
    logic        mem_fwd_valid;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        hazard_stall, ex_valid;
    logic [2:0]  ex_alu_op;
    logic [31:0] ex_r1, ex_r2;
    logic [4:0]  ex_rd_idx;
    logic        ex_reg_write, ex_is_load;

    int checks = 0;
    int errors = 0;

    id_ex_operand_stage #(.WORD_SIZE(32), .REG_IDX_W(5)) dut (
        .CLK(CLK), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_alu_op(in_alu_op),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc),
        .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
        .in_reg_write(in_reg_write), .in_is_load(in_is_load),
        .ex_fwd_data(ex_fwd_data), .mem_fwd_valid(mem_fwd_valid),
        .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_rd_idx(ex_rd_idx),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; in_valid = 0; in_alu_op = 0;
        in_rs1_idx = 0; in_rs2_idx = 0; in_rd_idx = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_pc = 0;
        in_src1_sel = 0; in_src2_sel = 0; in_reg_write = 0; in_is_load = 0;
        ex_fwd_data = 0; mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    endtask

    // Instruction that reads no registers (PC + immediate), writes rd.
    task automatic issue_nodep(input logic [4:0] rd, input logic ld);
        idle();
        in_valid = 1; in_rd_idx = rd; in_reg_write = 1; in_is_load = ld;
        in_src1_sel = 1; in_src2_sel = 1; in_pc = 32'h40; in_imm = 32'h4;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_valid"}, {31'b0, ex_valid}, 32'd0);
        check({tag, "_op"}, {29'b0, ex_alu_op}, 32'd0);
        check({tag, "_r1"}, ex_r1, 32'd0);
        check({tag, "_rd"}, {27'b0, ex_rd_idx}, 32'd0);
        check({tag, "_wr"}, {31'b0, ex_reg_write}, 32'd0);
        check({tag, "_ld"}, {31'b0, ex_is_load}, 32'd0);
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        check_bubble("reset");
        check("reset_r2", ex_r2, 32'd0);
        check("reset_haz", {31'b0, hazard_stall}, 32'd0);

        // Basic capture: r1 = rs1 data, r2 = immediate.
        rst = 0;
        idle();
        in_valid = 1; in_rs1_idx = 1; in_rs1_data = 5; in_imm = 7; in_src2_sel = 1;
        in_rd_idx = 2; in_reg_write = 1;
        #1 check("basic_haz", {31'b0, hazard_stall}, 32'd0);
        tick();
        check("basic_valid", {31'b0, ex_valid}, 32'd1);
        check("basic_r1", ex_r1, 32'd5);
        check("basic_r2", ex_r2, 32'd7);
        check("basic_rd", {27'b0, ex_rd_idx}, 32'd2);

        // x0 sources: EX holds rd=0 with reg_write; operands must be zero.
        issue_nodep(5'd0, 1'b0);
        tick();
        idle();
        in_valid = 1; in_rs1_data = 32'h99; in_rs2_data = 32'h99; in_rd_idx = 9;
        ex_fwd_data = 32'h77;
        #1 check("x0_haz", {31'b0, hazard_stall}, 32'd0);
        tick();
        check("x0_r1", ex_r1, 32'd0);
        check("x0_r2", ex_r2, 32'd0);

        // Downstream stall with changing inputs, then flush during stall.
        idle();
        in_valid = 1; in_alu_op = 3; in_src1_sel = 1; in_pc = 32'h100;
        in_src2_sel = 1; in_imm = 32'h44; in_rd_idx = 6; in_reg_write = 1;
        tick();
        check("cap_r1", ex_r1, 32'h100);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h200 + i; in_imm = 32'h900 + i; in_alu_op = 5; in_rd_idx = 11;
            tick();
            check("stall_r1", ex_r1, 32'h100);
            check("stall_r2", ex_r2, 32'h44);
            check("stall_op", {29'b0, ex_alu_op}, 32'd3);
            check("stall_rd", {27'b0, ex_rd_idx}, 32'd6);
        end
        flush = 1;
        tick();
        check_bubble("flush");

        // Load x4 in EX, consumer reads x4 as rs2.
        issue_nodep(5'd4, 1'b1);
        tick();
        idle();
        in_valid = 1; in_src1_sel = 1; in_pc = 32'h200; in_rs2_idx = 4;
        in_rs2_data = 32'hAA; in_rd_idx = 7; in_reg_write = 1;
        #1 check("lu_haz", {31'b0, hazard_stall}, 32'd1);
        flush = 1;
        #1 check("lu_haz_flush", {31'b0, hazard_stall}, 32'd0);
        flush = 0;
        #1;
        tick();
        check_bubble("lu_bubble");
        mem_fwd_valid = 1; mem_fwd_rd = 4; mem_fwd_data = 32'h55;
`ifdef ID_EX_FORWARD_EN
        #1 check("lu_mem_haz", {31'b0, hazard_stall}, 32'd0);
        tick();
        check("lu_r2", ex_r2, 32'h55);
        check("lu_r1", ex_r1, 32'h200);
`else
        #1 check("lu_mem_haz", {31'b0, hazard_stall}, 32'd1);
        tick();
        check("lu_bubble2", {31'b0, ex_valid}, 32'd0);
        mem_fwd_valid = 0;
        #1 check("lu_clear_haz", {31'b0, hazard_stall}, 32'd0);
        tick();
        check("lu_r2", ex_r2, 32'hAA);
        check("lu_r1", ex_r1, 32'h200);
`endif

        // ADD x3 then a consumer of x3 as rs1 (rf data 0xDEAD).
        issue_nodep(5'd3, 1'b0);
        tick();
        idle();
        in_valid = 1; in_rs1_idx = 3; in_rs1_data = 32'hDEAD; in_src2_sel = 1;
        in_imm = 1; in_rd_idx = 8; ex_fwd_data = 32'h10;
`ifdef ID_EX_FORWARD_EN
        #1 check("raw_haz", {31'b0, hazard_stall}, 32'd0);
        tick();
        check("raw_ex_r1", ex_r1, 32'h10);
        // EX now holds rd=8 without reg_write: MEM-only hit.
        mem_fwd_valid = 1; mem_fwd_rd = 3; mem_fwd_data = 32'h20;
        tick();
        check("raw_mem_r1", ex_r1, 32'h20);
        // EX and MEM both hit: EX wins.
        issue_nodep(5'd3, 1'b0);
        tick();
        idle();
        in_valid = 1; in_rs1_idx = 3; in_rs1_data = 32'hDEAD; in_src2_sel = 1;
        in_rd_idx = 8; ex_fwd_data = 32'h10;
        mem_fwd_valid = 1; mem_fwd_rd = 3; mem_fwd_data = 32'h20;
        tick();
        check("raw_both_r1", ex_r1, 32'h10);
`else
        #1 check("raw_haz_ex", {31'b0, hazard_stall}, 32'd1);
        tick();
        check("raw_bubble1", {31'b0, ex_valid}, 32'd0);
        mem_fwd_valid = 1; mem_fwd_rd = 3; mem_fwd_data = 32'h10;
        #1 check("raw_haz_mem", {31'b0, hazard_stall}, 32'd1);
        tick();
        check("raw_bubble2", {31'b0, ex_valid}, 32'd0);
        mem_fwd_valid = 0;
        #1 check("raw_haz_clear", {31'b0, hazard_stall}, 32'd0);
        tick();
        check("raw_valid", {31'b0, ex_valid}, 32'd1);
        check("raw_rf_r1", ex_r1, 32'hDEAD);
`endif

        // Reset asserted while a load-use hazard is pending.
        issue_nodep(5'd12, 1'b1);
        tick();
        idle();
        in_valid = 1; in_rs1_idx = 12; in_rs1_data = 32'h3; in_rd_idx = 13; in_reg_write = 1;
        #1 check("rst_haz_pre", {31'b0, hazard_stall}, 32'd1);
        rst = 1;
        #1 check("rst_haz_drop", {31'b0, hazard_stall}, 32'd0);
        tick();
        check_bubble("rst_mid");
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
